// File: rtl/control_pkg.sv
// Shared constants, state encodings and control-word layout for the multi-cycle control unit.
package control_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned CWOP_W  = 2;
    localparam int unsigned SRCB_W  = 2;
    localparam int unsigned PCSRC_W = 2;

    // Opcodes (op[5:0])
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPC_W-1:0] OP_J     = 6'd2;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OPC_W-1:0] OP_LW    = 6'd35;
    localparam logic [OPC_W-1:0] OP_SW    = 6'd43;

    // ALU operation classes
    localparam logic [CWOP_W-1:0] ALU_ADD   = 2'd0;
    localparam logic [CWOP_W-1:0] ALU_SUB   = 2'd1;
    localparam logic [CWOP_W-1:0] ALU_FUNCT = 2'd2;

    // ALU B operand select
    localparam logic [SRCB_W-1:0] SRCB_REGB    = 2'd0;
    localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'd1;
    localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'd2;
    localparam logic [SRCB_W-1:0] SRCB_IMM_SH2 = 2'd3;

    // PC source select
    localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'd0;
    localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_TRAP     = 4'd15
    } state_e;

    typedef struct packed {
        logic                pc_write;
        logic                pc_write_cond;
        logic                branch_ne;
        logic                i_or_d;
        logic                mem_read;
        logic                mem_write;
        logic                ir_write;
        logic                mem_to_reg;
        logic                reg_dst;
        logic                reg_write;
        logic                alu_src_a;
        logic [SRCB_W-1:0]   alu_src_b;
        logic [CWOP_W-1:0]   alu_op;
        logic [PCSRC_W-1:0]  pc_source;
        logic                illegal;
    } ctrl_word_t;

endpackage

// File: rtl/control_out_decode.sv
// Combinational state -> control-word decode (Moore outputs, FETCH strobes qualified by mem_ready).
module control_out_decode
    import control_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    input  logic       branch_ne_i,
    output ctrl_word_t ctrl_c
);

    // One control word per state; anything not set stays 0
    always_comb begin
        ctrl_c = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.ir_write  = mem_ready_i;
                ctrl_c.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMM_SH2;
                ctrl_c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REGB;
                ctrl_c.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_src_b     = SRCB_REGB;
                ctrl_c.alu_op        = ALU_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = PCSRC_ALUOUT;
                ctrl_c.branch_ne     = branch_ne_i;
            end
            S_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCSRC_JUMP;
            end
            S_ADDI_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl_c.reg_write = 1'b1;
            end
            S_TRAP: begin
                ctrl_c.illegal = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset control unit: state sequencing, branch polarity latch, gated outputs.
module multicycle_control
    import control_pkg::*;
#(
    parameter int unsigned OP_W        = 6,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned ADDI_EN     = 1,
    parameter int unsigned BNE_EN      = 1,
    parameter int unsigned MEM_WAIT_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal,
    output logic [3:0]         state
);

    state_e     state_q, state_d;
    logic       branch_ne_q, branch_ne_d;
    logic       mem_rdy;
    ctrl_word_t cw;

    // Full-width compare: nonzero upper opcode bits never match a legal opcode
    function automatic logic op_is(input logic [OP_W-1:0] o, input logic [OPC_W-1:0] code);
        return o == OP_W'(code);
    endfunction

    assign mem_rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    // State and branch-polarity registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            branch_ne_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            branch_ne_q <= branch_ne_d;
        end
    end

    // Next-state logic; branch polarity captured on DECODE exit
    always_comb begin
        state_d     = state_q;
        branch_ne_d = branch_ne_q;
        case (state_q)
            S_FETCH:    if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                branch_ne_d = op_is(op, OP_BNE);
                if (op_is(op, OP_LW) || op_is(op, OP_SW))  state_d = S_MEM_ADDR;
                else if (op_is(op, OP_RTYPE))              state_d = S_EXEC;
                else if (op_is(op, OP_BEQ))                state_d = S_BRANCH;
                else if (op_is(op, OP_BNE) && BNE_EN != 0) state_d = S_BRANCH;
                else if (op_is(op, OP_J))                  state_d = S_JUMP;
                else if (op_is(op, OP_ADDI) && ADDI_EN != 0) state_d = S_ADDI_EX;
                else                                       state_d = S_TRAP;
            end
            S_MEM_ADDR: state_d = op_is(op, OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_rdy) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (mem_rdy) state_d = S_FETCH;
            S_EXEC:     state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    control_out_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_rdy),
        .branch_ne_i (branch_ne_q),
        .ctrl_c      (cw)
    );

    // Every output forced low while reset is asserted
    assign pc_write      = cw.pc_write      & rst_n;
    assign pc_write_cond = cw.pc_write_cond & rst_n;
    assign branch_ne     = cw.branch_ne     & rst_n;
    assign i_or_d        = cw.i_or_d        & rst_n;
    assign mem_read      = cw.mem_read      & rst_n;
    assign mem_write     = cw.mem_write     & rst_n;
    assign ir_write      = cw.ir_write      & rst_n;
    assign mem_to_reg    = cw.mem_to_reg    & rst_n;
    assign reg_dst       = cw.reg_dst       & rst_n;
    assign reg_write     = cw.reg_write     & rst_n;
    assign alu_src_a     = cw.alu_src_a     & rst_n;
    assign alu_src_b     = cw.alu_src_b     & {2{rst_n}};
    assign alu_op        = ALUOP_W'(cw.alu_op) & {ALUOP_W{rst_n}};
    assign pc_source     = cw.pc_source     & {2{rst_n}};
    assign illegal       = cw.illegal       & rst_n;
    assign state         = 4'(state_q)      & {4{rst_n}};

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state sequences and control words per instruction class.
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] op_a, op_b;
    logic       mem_ready;

    logic       pc_write_a, pc_write_cond_a, branch_ne_a, i_or_d_a, mem_read_a, mem_write_a;
    logic       ir_write_a, mem_to_reg_a, reg_dst_a, reg_write_a, alu_src_a_a, illegal_a;
    logic [1:0] alu_src_b_a, alu_op_a, pc_source_a;
    logic [3:0] state_a;

    logic       pc_write_b, pc_write_cond_b, branch_ne_b, i_or_d_b, mem_read_b, mem_write_b;
    logic       ir_write_b, mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, illegal_b;
    logic [1:0] alu_src_b_b, alu_op_b, pc_source_b;
    logic [3:0] state_b;

    logic        sel_b;
    logic [17:0] ctl_a, ctl_b, got_ctl;
    logic [3:0]  got_state;

    int n_vec  = 0;
    int n_miss = 0;
    int rw_cnt = 0;
    int mw_cnt = 0;

    multicycle_control u_dut_a (
        .clk(clk), .rst_n(rst_n), .op(op_a), .mem_ready(mem_ready),
        .pc_write(pc_write_a), .pc_write_cond(pc_write_cond_a), .branch_ne(branch_ne_a),
        .i_or_d(i_or_d_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
        .ir_write(ir_write_a), .mem_to_reg(mem_to_reg_a), .reg_dst(reg_dst_a),
        .reg_write(reg_write_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
        .alu_op(alu_op_a), .pc_source(pc_source_a), .illegal(illegal_a), .state(state_a)
    );

    multicycle_control #(.ADDI_EN(0), .BNE_EN(0), .MEM_WAIT_EN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .op(op_b), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .branch_ne(branch_ne_b),
        .i_or_d(i_or_d_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
        .ir_write(ir_write_b), .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b),
        .reg_write(reg_write_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
        .alu_op(alu_op_b), .pc_source(pc_source_b), .illegal(illegal_b), .state(state_b)
    );

    // Bit layout: pw pwc bne iod mr mw irw m2r rd rw asa asb[2] aop[2] pcs[2] ill
    assign ctl_a = {pc_write_a, pc_write_cond_a, branch_ne_a, i_or_d_a, mem_read_a, mem_write_a,
                    ir_write_a, mem_to_reg_a, reg_dst_a, reg_write_a, alu_src_a_a,
                    alu_src_b_a, alu_op_a, pc_source_a, illegal_a};
    assign ctl_b = {pc_write_b, pc_write_cond_b, branch_ne_b, i_or_d_b, mem_read_b, mem_write_b,
                    ir_write_b, mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b,
                    alu_src_b_b, alu_op_b, pc_source_b, illegal_b};
    assign got_ctl   = sel_b ? ctl_b : ctl_a;
    assign got_state = sel_b ? state_b : state_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] cw(
        input logic pw, input logic pwc, input logic bne, input logic iod, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rd, input logic rw,
        input logic asa, input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] pcs,
        input logic ill);
        return {pw, pwc, bne, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
    endfunction

    // Hand-written expected control word per state
    function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic rdy, input logic bne);
        case (st)
            4'd0:  return cw(rdy, 0, 0, 0, 1, 0, rdy, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 0);
            4'd1:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 0);
            4'd2:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0);
            4'd3:  return cw(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
            4'd4:  return cw(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0);
            4'd5:  return cw(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0);
            4'd6:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd0, 0);
            4'd7:  return cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0);
            4'd8:  return cw(0, 1, bne, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd1, 0);
            4'd9:  return cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0);
            4'd10: return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0, 0);
            4'd11: return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0);
            4'd15: return cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1);
            default: return 18'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive mem_ready mid-cycle, then check state and the whole control word
    task automatic step(input logic [3:0] st, input logic rdy, input logic bne, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        #1;
        check({tag, " state"}, 32'(got_state), 32'(st));
        check({tag, " ctl"}, 32'(got_ctl), 32'(exp_ctl(st, rdy | sel_b, bne)));
        if (got_ctl[8])  rw_cnt++;
        if (got_ctl[12]) mw_cnt++;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check({tag, " rst state"}, 32'(got_state), 32'd0);
        check({tag, " rst ctl"}, 32'(got_ctl), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        op_a      = 6'd0;
        op_b      = 6'd0;
        mem_ready = 1'b1;
        sel_b     = 1'b0;
        do_reset("init");

        // FETCH waits on mem_ready, then R-type
        op_a = 6'd0;
        step(4'd0, 1'b0, 1'b0, "fetch wait");
        step(4'd0, 1'b1, 1'b0, "r f");
        step(4'd1, 1'b1, 1'b0, "r d");
        step(4'd6, 1'b1, 1'b0, "r ex");
        step(4'd7, 1'b1, 1'b0, "r wb");

        // lw with two wait cycles in MEM_RD
        op_a = 6'd35; rw_cnt = 0;
        step(4'd0, 1'b1, 1'b0, "lw f");
        step(4'd1, 1'b1, 1'b0, "lw d");
        step(4'd2, 1'b1, 1'b0, "lw ad");
        step(4'd3, 1'b0, 1'b0, "lw rd0");
        step(4'd3, 1'b0, 1'b0, "lw rd1");
        step(4'd3, 1'b1, 1'b0, "lw rd2");
        step(4'd4, 1'b1, 1'b0, "lw wb");
        check("lw reg_write count", 32'(rw_cnt), 32'd1);

        // sw
        op_a = 6'd43; rw_cnt = 0; mw_cnt = 0;
        step(4'd0, 1'b1, 1'b0, "sw f");
        step(4'd1, 1'b1, 1'b0, "sw d");
        step(4'd2, 1'b1, 1'b0, "sw ad");
        step(4'd5, 1'b1, 1'b0, "sw wr");
        check("sw mem_write count", 32'(mw_cnt), 32'd1);
        check("sw reg_write count", 32'(rw_cnt), 32'd0);

        // beq, bne, j, addi
        op_a = 6'd4;
        step(4'd0, 1'b1, 1'b0, "beq f");
        step(4'd1, 1'b1, 1'b0, "beq d");
        step(4'd8, 1'b1, 1'b0, "beq br");
        op_a = 6'd5;
        step(4'd0, 1'b1, 1'b0, "bne f");
        step(4'd1, 1'b1, 1'b0, "bne d");
        step(4'd8, 1'b1, 1'b1, "bne br");
        op_a = 6'd2;
        step(4'd0, 1'b1, 1'b0, "j f");
        step(4'd1, 1'b1, 1'b0, "j d");
        step(4'd9, 1'b1, 1'b0, "j jmp");
        op_a = 6'd8;
        step(4'd0, 1'b1, 1'b0, "addi f");
        step(4'd1, 1'b1, 1'b0, "addi d");
        step(4'd10, 1'b1, 1'b0, "addi ex");
        step(4'd11, 1'b1, 1'b0, "addi wb");

        // Illegal opcode 63: sticky trap, only illegal asserted
        op_a = 6'd63;
        step(4'd0, 1'b1, 1'b0, "op63 f");
        step(4'd1, 1'b1, 1'b0, "op63 d");
        for (int i = 0; i < 20; i++) begin
            op_a = (i == 5) ? 6'd0 : op_a;
            step(4'd15, 1'(i & 1), 1'b0, "op63 trap");
        end
        do_reset("trap clr");
        step(4'd0, 1'b1, 1'b0, "post trap f");

        // Reset asserted while MEM_WR is waiting
        op_a = 6'd43;
        step(4'd1, 1'b1, 1'b0, "swr d");
        step(4'd2, 1'b1, 1'b0, "swr ad");
        step(4'd5, 1'b0, 1'b0, "swr wait");
        rst_n = 1'b0;
        #1;
        check("swr mem_write drop", 32'(mem_write_a), 32'd0);
        check("swr state", 32'(state_a), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        op_a = 6'd0;
        step(4'd0, 1'b1, 1'b0, "swr restart");
        step(4'd1, 1'b1, 1'b0, "swr restart d");

        // Reduced build: addi and bne trap, mem_ready ignored
        sel_b = 1'b1;
        do_reset("b init");
        op_b = 6'd8;
        step(4'd0, 1'b0, 1'b0, "b addi f");
        step(4'd1, 1'b0, 1'b0, "b addi d");
        for (int i = 0; i < 20; i++) step(4'd15, 1'b0, 1'b0, "b addi trap");
        do_reset("b clr1");
        op_b = 6'd5;
        step(4'd0, 1'b0, 1'b0, "b bne f");
        step(4'd1, 1'b0, 1'b0, "b bne d");
        step(4'd15, 1'b0, 1'b0, "b bne trap");
        do_reset("b clr2");
        op_b = 6'd35;
        step(4'd0, 1'b0, 1'b0, "b lw f");
        step(4'd1, 1'b0, 1'b0, "b lw d");
        step(4'd2, 1'b0, 1'b0, "b lw ad");
        step(4'd3, 1'b0, 1'b0, "b lw rd");
        step(4'd4, 1'b0, 1'b0, "b lw wb");
        step(4'd0, 1'b0, 1'b0, "b lw next f");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
